// File: rtl/rv_ctrl_pkg.sv
// Shared opcode, state and mux-select encodings for the RV32I multicycle controller.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  function automatic logic op_is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_AUIPC,
      OP_LUI, OP_BRANCH, OP_JAL, OP_JALR: op_is_legal = 1'b1;
      default:                            op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; flags the last permitted wait cycle.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  // cnt holds the number of wait cycles already elapsed, so this cycle is wait number cnt+1.
  assign timeout = enable && (cnt == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the RV32I multicycle datapath: fetch, decode, execute, memory, writeback.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic [6:0]  alu_opcode,
  output logic [3:0]  alu_funct,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        illegal,
  output logic        bus_error,
  output logic [2:0]  state
);

  state_t      cur_q, nxt;
  logic [31:0] instr_q;
  logic        illegal_q, bus_error_q;
  logic        timeout, tmr_en, tmr_clr;
  logic        set_illegal, set_bus;

  logic        ir_write_c, pc_write_c, mem_req_c, mem_we_c, addr_sel_c;
  logic        alu_src_b_c, reg_write_c, retire_c;
  logic [1:0]  pc_sel_c, wb_sel_c;

  logic [6:0]  op;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_r;
  logic        unused_ir;

  assign op        = instr_q[6:0];
  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign is_branch = (op == OP_BRANCH);
  assign is_jal    = (op == OP_JAL);
  assign is_jalr   = (op == OP_JALR);
  assign is_r      = (op == OP_R);
  assign unused_ir = ^{instr_q[31], instr_q[29:15]};

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .timeout(timeout)
  );

  // The counter runs only while stalled in a request state; any other cycle restarts it.
  assign tmr_en  = ((cur_q == S_FETCH) || (cur_q == S_MEMORY)) && !mem_ready;
  assign tmr_clr = !tmr_en;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_q       <= S_FETCH;
      instr_q     <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      cur_q <= nxt;
      if (ir_write_c)  instr_q     <= instr;
      if (set_illegal) illegal_q   <= 1'b1;
      if (set_bus)     bus_error_q <= 1'b1;
    end
  end

  always_comb begin
    nxt         = cur_q;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_sel_c    = PC_PLUS4;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    addr_sel_c  = 1'b0;
    alu_src_b_c = 1'b0;
    reg_write_c = 1'b0;
    wb_sel_c    = WB_ALU;
    retire_c    = 1'b0;
    set_illegal = 1'b0;
    set_bus     = 1'b0;
    case (cur_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          nxt        = S_DECODE;
        end else if (timeout) begin
          set_bus = 1'b1;
          nxt     = S_TRAP;
        end
      end
      S_DECODE: begin
        if (op_is_legal(op)) nxt = S_EXECUTE;
        else begin
          set_illegal = 1'b1;
          nxt         = S_TRAP;
        end
      end
      S_EXECUTE: begin
        alu_src_b_c = !(is_r || is_branch);
        if (is_load || is_store) nxt = S_MEMORY;
        else if (is_branch) begin
          pc_write_c = alu_zero;
          pc_sel_c   = PC_REL;
          retire_c   = 1'b1;
          nxt        = S_FETCH;
        end else nxt = S_WRITEBACK;
      end
      S_MEMORY: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = is_store;
        if (mem_ready) begin
          retire_c = is_store;
          nxt      = is_store ? S_FETCH : S_WRITEBACK;
        end else if (timeout) begin
          set_bus = 1'b1;
          nxt     = S_TRAP;
        end
      end
      S_WRITEBACK: begin
        reg_write_c = |instr_q[11:7];
        wb_sel_c    = is_load ? WB_MEM : ((is_jal || is_jalr) ? WB_PC4 : WB_ALU);
        pc_write_c  = is_jal || is_jalr;
        pc_sel_c    = is_jalr ? PC_JALR : (is_jal ? PC_REL : PC_PLUS4);
        retire_c    = 1'b1;
        nxt         = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
  end

  // Controls are forced quiet while reset is held, even though the state register already reads FETCH.
  assign ir_write   = ir_write_c  & reset_n;
  assign pc_write   = pc_write_c  & reset_n;
  assign pc_sel     = reset_n ? pc_sel_c : PC_PLUS4;
  assign mem_req    = mem_req_c   & reset_n;
  assign mem_we     = mem_we_c    & reset_n;
  assign addr_sel   = addr_sel_c  & reset_n;
  assign alu_src_b  = alu_src_b_c & reset_n;
  assign reg_write  = reg_write_c & reset_n;
  assign wb_sel     = reset_n ? wb_sel_c : WB_ALU;
  assign retire     = retire_c    & reset_n;

  assign alu_opcode = instr_q[6:0];
  assign alu_funct  = {instr_q[30], instr_q[14:12]};
  assign illegal    = illegal_q;
  assign bus_error  = bus_error_q;
  assign state      = cur_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: per-instruction cycle schedules built from the ISA rules, compared every cycle.
module tb_multicycle_control;

  localparam int TMO = 255;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_write, pc_write, mem_req, mem_we, addr_sel, alu_src_b, reg_write, retire;
  logic        illegal, bus_error;
  logic [1:0]  pc_sel, wb_sel;
  logic [6:0]  alu_opcode;
  logic [3:0]  alu_funct;
  logic [2:0]  state;

  multicycle_control #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .instr(instr), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .alu_opcode(alu_opcode),
    .alu_funct(alu_funct), .alu_src_b(alu_src_b), .reg_write(reg_write), .wb_sel(wb_sel),
    .retire(retire), .illegal(illegal), .bus_error(bus_error), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  st;
    logic        ir_write, pc_write;
    logic [1:0]  pc_sel;
    logic        mem_req, mem_we, addr_sel, alu_src_b, reg_write;
    logic [1:0]  wb_sel;
    logic        retire, illegal, bus_error;
    logic [31:0] ins;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ncyc;
  exp_t cur_exp;
  bit   exp_valid = 1'b0;
  logic m_illegal = 1'b0, m_bus = 1'b0;
  logic [31:0] cur_ins = '0;
  logic [6:0]  cap_op;
  logic [3:0]  cap_fn;

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b0010111, 7'b0110111, 7'b1100011, 7'b1101111, 7'b1100111};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Per-cycle comparison of the DUT against the scheduled expectation.
  always @(negedge clock) begin
    #2;
    if (exp_valid && reset_n) begin
      chk("state", state, cur_exp.st);
      chk("ir_write", ir_write, cur_exp.ir_write);
      chk("pc_write", pc_write, cur_exp.pc_write);
      chk("mem_req", mem_req, cur_exp.mem_req);
      chk("mem_we", mem_we, cur_exp.mem_we);
      chk("reg_write", reg_write, cur_exp.reg_write);
      chk("retire", retire, cur_exp.retire);
      chk("illegal", illegal, cur_exp.illegal);
      chk("bus_error", bus_error, cur_exp.bus_error);
      if (cur_exp.pc_write) chk("pc_sel", pc_sel, cur_exp.pc_sel);
      if (cur_exp.mem_req)  chk("addr_sel", addr_sel, cur_exp.addr_sel);
      if (cur_exp.st == 3'd2) begin
        chk("alu_src_b", alu_src_b, cur_exp.alu_src_b);
        cap_op = alu_opcode;
        cap_fn = alu_funct;
      end
      if (cur_exp.st == 3'd4) chk("wb_sel", wb_sel, cur_exp.wb_sel);
      if (cur_exp.st >= 3'd1 && cur_exp.st <= 3'd4) begin
        chk("alu_opcode", alu_opcode, cur_exp.ins[6:0]);
        chk("alu_funct", alu_funct, {cur_exp.ins[30], cur_exp.ins[14:12]});
      end
    end
  end

  function automatic exp_t base(input logic [2:0] st);
    exp_t e;
    e           = '0;
    e.st        = st;
    e.illegal   = m_illegal;
    e.bus_error = m_bus;
    e.ins       = cur_ins;
    return e;
  endfunction

  task automatic step(input exp_t e, input logic rdy, input logic az);
    @(negedge clock);
    mem_ready = rdy;
    alu_zero  = az;
    instr     = cur_ins;
    cur_exp   = e;
    exp_valid = 1'b1;
    ncyc++;
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // res: 0 retired, 1 illegal trap, 2 bus trap, 3 stopped early (stop_at cycles)
  task automatic run_instr(input logic [31:0] ins, input int fd, input int md,
                           input logic az, input int stop_at, output int res);
    exp_t e;
    logic [6:0] op;
    bit ld, stv, jl, jr;
    op = ins[6:0];
    ld = (op == 7'b0000011); stv = (op == 7'b0100011);
    jl = (op == 7'b1101111); jr = (op == 7'b1100111);
    res = 0; ncyc = 0; cur_ins = ins;
    for (int i = 0; i < fd && i < TMO; i++) begin
      e = base(3'd0); e.mem_req = 1'b1;
      step(e, 1'b0, rb());
    end
    if (fd >= TMO) begin m_bus = 1'b1; res = 2; return; end
    e = base(3'd0); e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1; e.pc_sel = 2'd0;
    step(e, 1'b1, rb());
    step(base(3'd1), rb(), rb());
    if (!is_legal(op)) begin m_illegal = 1'b1; res = 1; return; end
    e = base(3'd2);
    e.alu_src_b = !(op == 7'b0110011 || op == 7'b1100011);
    if (op == 7'b1100011) begin
      e.pc_write = az; e.pc_sel = 2'd1; e.retire = 1'b1;
      step(e, rb(), az);
      return;
    end
    step(e, rb(), rb());
    if (ld || stv) begin
      for (int i = 0; i < md && i < TMO; i++) begin
        e = base(3'd3); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = stv;
        step(e, 1'b0, rb());
        if (stop_at > 0 && ncyc >= stop_at) begin res = 3; return; end
      end
      if (md >= TMO) begin m_bus = 1'b1; res = 2; return; end
      e = base(3'd3); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = stv; e.retire = stv;
      step(e, 1'b1, rb());
      if (stv) return;
    end
    e = base(3'd4);
    e.reg_write = (ins[11:7] != 5'd0);
    e.wb_sel    = ld ? 2'd1 : ((jl || jr) ? 2'd2 : 2'd0);
    e.pc_write  = jl || jr;
    e.pc_sel    = jr ? 2'd2 : 2'd1;
    e.retire    = 1'b1;
    step(e, rb(), rb());
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) step(base(3'd5), rb(), rb());
  endtask

  task automatic do_reset();
    #4;
    exp_valid = 1'b0;
    reset_n   = 1'b0;
    mem_ready = rb();
    #1;
    chk("rst_state", state, 3'd0);
    chk("rst_strobes", {ir_write, pc_write, mem_req, mem_we, reg_write, retire}, 6'd0);
    chk("rst_flags", {illegal, bus_error}, 2'd0);
    chk("rst_opcode", alu_opcode, 7'd0);
    m_illegal = 1'b0; m_bus = 1'b0; cur_ins = '0;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int res;
    logic [31:0] ins;
    logic [6:0]  op;

    do_reset();

    // add x3,x1,x2
    run_instr(32'h002081B3, 0, 0, 1'b0, 0, res);
    #4;
    chk("add_cycles", ncyc, 4);
    chk("add_op", cap_op, 7'b0110011);
    chk("add_fn", cap_fn, 4'b0000);
    // lw x5,8(x1) with three stalled memory cycles
    run_instr(32'h0080A283, 0, 3, 1'b0, 0, res);
    #4;
    chk("lw_cycles", ncyc, 8);
    chk("lw_fn", cap_fn, 4'b0010);
    // sw x2,4(x1)
    run_instr(32'h0020A223, 0, 0, 1'b0, 0, res);
    #4;
    chk("sw_cycles", ncyc, 4);
    chk("sw_op", cap_op, 7'b0100011);
    // beq taken / not taken
    run_instr(32'h00208463, 0, 0, 1'b1, 0, res);
    #4;
    chk("beq_t_cycles", ncyc, 3);
    run_instr(32'h00208463, 0, 0, 1'b0, 0, res);
    #4;
    chk("beq_nt_cycles", ncyc, 3);
    chk("beq_op", cap_op, 7'b1100011);
    // mem_ready arriving on the last permitted fetch wait cycle
    run_instr(32'h002081B3, TMO - 1, 0, 1'b0, 0, res);
    #4;
    chk("fetch_edge_res", res, 0);
    chk("fetch_edge_cycles", ncyc, TMO - 1 + 4);

    // illegal opcode
    run_instr(32'h00000000, 0, 0, 1'b0, 0, res);
    trap_cycles(4);
    do_reset();
    // fetch timeout
    run_instr(32'h002081B3, TMO, 0, 1'b0, 0, res);
    trap_cycles(3);
    do_reset();
    // store timeout in MEMORY
    run_instr(32'h0020A223, 0, TMO, 1'b0, 0, res);
    trap_cycles(3);
    do_reset();

    // reset pulsed mid-MEMORY
    run_instr(32'h0080A283, 0, 10, 1'b0, 5, res);
    #4;
    exp_valid = 1'b0;
    chk("mid_mem_req_before", mem_req, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_mem_req_drop", mem_req, 1'b0);
    chk("mid_state", state, 3'd0);
    m_illegal = 1'b0; m_bus = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk("mid_flags", {illegal, bus_error}, 2'd0);
    run_instr(32'h002081B3, 0, 0, 1'b0, 0, res);

    // random instruction stream
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        op = 7'($urandom);
        while (is_legal(op)) op = 7'($urandom);
      end else begin
        op = legal_ops[$urandom_range(0, 8)];
      end
      ins = $urandom;
      ins[6:0] = op;
      if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), rb(), 0, res);
      if (res != 0) begin
        trap_cycles(2);
        do_reset();
      end
    end

    #4;
    exp_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
